// File: rtl/lcd_scan_pkg.sv
// lcd_scan_pkg: phase encoding, default panel timing and counter width
// shared by the 480x272 LCD scan generator and its axis counters.
package lcd_scan_pkg;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } scan_phase_t;

    localparam int DEF_PCLK_DIV = 3;
    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FRONT  = 2;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BACK   = 2;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FRONT  = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BACK   = 2;

    function automatic scan_phase_t next_phase(input scan_phase_t p);
        scan_phase_t n;
        n = ACTIVE;
        unique case (p)
            ACTIVE: n = FRONT;
            FRONT:  n = SYNC;
            SYNC:   n = BACK;
            BACK:   n = ACTIVE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lcd_scan_axis.sv
// lcd_scan_axis: one timing axis (horizontal or vertical) cycling through
// ACTIVE/FRONT/SYNC/BACK; wrap flags the advance that leaves BACK.
module lcd_scan_axis
    import lcd_scan_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    input  logic [CNT_W-1:0] len_active,
    input  logic [CNT_W-1:0] len_front,
    input  logic [CNT_W-1:0] len_sync,
    input  logic [CNT_W-1:0] len_back,
    output scan_phase_t      phase,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    scan_phase_t      phase_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] cur_len;
    logic             last;

    always_comb begin
        cur_len = len_active;
        unique case (phase)
            ACTIVE: cur_len = len_active;
            FRONT:  cur_len = len_front;
            SYNC:   cur_len = len_sync;
            BACK:   cur_len = len_back;
        endcase
    end

    assign last = (count == cur_len - CNT_W'(1));
    assign wrap = advance && last && (phase == BACK);

    always_comb begin
        phase_next = phase;
        count_next = count;
        if (advance) begin
            if (last) begin
                count_next = '0;
                phase_next = next_phase(phase);
            end else begin
                count_next = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= ACTIVE;
            count <= '0;
        end else begin
            phase <= phase_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/lcd_480x272_scan.sv
// lcd_480x272_scan: scan generator and registered pixel output stage for the
// Tang Nano 9K 480x272 panel; LCD_480X272_SCAN_TEST_PATTERN_EN selects colour bars.
module lcd_480x272_scan
    import lcd_scan_pkg::*;
#(
    parameter int pclk_div = DEF_PCLK_DIV,
    parameter int h_active = DEF_H_ACTIVE,
    parameter int h_front  = DEF_H_FRONT,
    parameter int h_sync   = DEF_H_SYNC,
    parameter int h_back   = DEF_H_BACK,
    parameter int v_active = DEF_V_ACTIVE,
    parameter int v_front  = DEF_V_FRONT,
    parameter int v_sync   = DEF_V_SYNC,
    parameter int v_back   = DEF_V_BACK
) (
    input  logic       clock,
    input  logic       reset,
    output logic [8:0] x,
    output logic [8:0] y,
    input  logic [4:0] red,
    input  logic [5:0] green,
    input  logic [4:0] blue,
    output logic       frame_start,
    output logic       lcd_pclk,
    output logic       lcd_de,
    output logic       lcd_hsync,
    output logic       lcd_vsync,
    output logic [4:0] lcd_red,
    output logic [5:0] lcd_green,
    output logic [4:0] lcd_blue
);

    localparam int DIV_W = $clog2(pclk_div);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(pclk_div - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(pclk_div / 2);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             tick;

    assign tick     = (div_cnt == DIV_LAST);
    assign div_next = tick ? '0 : div_cnt + DIV_W'(1);

    scan_phase_t      h_phase;
    scan_phase_t      v_phase;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_wrap;
    logic             v_wrap;
    logic             active;

    lcd_scan_axis u_h_axis (
        .clock      (clock),
        .reset      (reset),
        .advance    (tick),
        .len_active (CNT_W'(h_active)),
        .len_front  (CNT_W'(h_front)),
        .len_sync   (CNT_W'(h_sync)),
        .len_back   (CNT_W'(h_back)),
        .phase      (h_phase),
        .count      (h_count),
        .wrap       (h_wrap)
    );

    lcd_scan_axis u_v_axis (
        .clock      (clock),
        .reset      (reset),
        .advance    (tick && h_wrap),
        .len_active (CNT_W'(v_active)),
        .len_front  (CNT_W'(v_front)),
        .len_sync   (CNT_W'(v_sync)),
        .len_back   (CNT_W'(v_back)),
        .phase      (v_phase),
        .count      (v_count),
        .wrap       (v_wrap)
    );

    assign active = (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign x      = active ? h_count[8:0] : '0;
    assign y      = active ? v_count[8:0] : '0;

    logic unused_cnt_msb;
    assign unused_cnt_msb = h_count[CNT_W-1] ^ v_count[CNT_W-1];

    logic [4:0] pix_r;
    logic [5:0] pix_g;
    logic [4:0] pix_b;

`ifdef LCD_480X272_SCAN_TEST_PATTERN_EN
    localparam int BAR_W = h_active / 8;

    logic [2:0] bar;
    logic       unused_rgb;

    // Bar index from seven threshold compares instead of a divider
    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (CNT_W'(x) >= CNT_W'(k * BAR_W))
                bar = bar + 3'd1;
        end
    end

    assign pix_r      = {5{bar[2]}};
    assign pix_g      = {6{bar[1]}};
    assign pix_b      = {5{bar[0]}};
    assign unused_rgb = ^{red, green, blue};
`else
    assign pix_r = red;
    assign pix_g = green;
    assign pix_b = blue;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt     <= '0;
            lcd_pclk    <= 1'b0;
            frame_start <= 1'b0;
            lcd_de      <= 1'b0;
            lcd_hsync   <= 1'b1;
            lcd_vsync   <= 1'b1;
            lcd_red     <= '0;
            lcd_green   <= '0;
            lcd_blue    <= '0;
        end else begin
            div_cnt     <= div_next;
            lcd_pclk    <= (div_next >= DIV_HALF);
            // Frame wrap lands both axes on (0,0) at this edge
            frame_start <= tick && h_wrap && v_wrap;
            if (tick) begin
                lcd_de    <= active;
                lcd_hsync <= (h_phase != SYNC);
                lcd_vsync <= (v_phase != SYNC);
                lcd_red   <= active ? pix_r : '0;
                lcd_green <= active ? pix_g : '0;
                lcd_blue  <= active ? pix_b : '0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_480x272_scan.sv
// tb_lcd_480x272_scan: scoreboard bench for the LCD scan generator,
// run with a shrunken timing set so several frames fit in a short run.
module tb_lcd_480x272_scan;

    localparam int PD = 3;
    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 2;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int VS = 3;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } out_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] x;
    logic [8:0] y;
    logic [4:0] red   = '0;
    logic [5:0] green = '0;
    logic [4:0] blue  = '0;
    logic       frame_start;
    logic       lcd_pclk;
    logic       lcd_de;
    logic       lcd_hsync;
    logic       lcd_vsync;
    logic [4:0] lcd_red;
    logic [5:0] lcd_green;
    logic [4:0] lcd_blue;

    lcd_480x272_scan #(
        .pclk_div (PD),
        .h_active (HA),
        .h_front  (HF),
        .h_sync   (HS),
        .h_back   (HB),
        .v_active (VA),
        .v_front  (VF),
        .v_sync   (VS),
        .v_back   (VB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start),
        .lcd_pclk    (lcd_pclk),
        .lcd_de      (lcd_de),
        .lcd_hsync   (lcd_hsync),
        .lcd_vsync   (lcd_vsync),
        .lcd_red     (lcd_red),
        .lcd_green   (lcd_green),
        .lcd_blue    (lcd_blue)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int     errors = 0;
    int     checks = 0;
    out_t   exp_q[$];
    int     hp;
    int     lp;
    int     frames;
    longint last_fs;
    int     de_seen;
    int     hs_low;
    int     vs_low;

    task automatic do_reset();
        out_t r0;
        reset = 1'b1;
        red   = '0;
        green = '0;
        blue  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset   = 1'b0;
        hp      = 0;
        lp      = 0;
        frames  = 0;
        last_fs = -1;
        r0      = '{de: 1'b0, hs: 1'b1, vs: 1'b1, r: '0, g: '0, b: '0};
        exp_q.delete();
        exp_q.push_back(r0);
    endtask

    // Called at the falling edge in the first clock of the model's pixel
    task automatic step_pixel();
        out_t       e;
        out_t       got;
        logic       act;
        logic       hsy;
        logic       vsy;
        logic       fs_exp;
        logic [8:0] ex;
        logic [8:0] ey;
`ifdef LCD_480X272_SCAN_TEST_PATTERN_EN
        logic [2:0] bar;
`endif
        act = (hp < HA) && (lp < VA);
        hsy = (hp >= HA + HF) && (hp < HA + HF + HS);
        vsy = (lp >= VA + VF) && (lp < VA + VF + VS);
        ex  = act ? 9'(hp) : 9'd0;
        ey  = act ? 9'(lp) : 9'd0;

        checks++;
        if (x !== ex || y !== ey) begin
            errors++;
            $display("FAIL xy: got x=%0d y=%0d want x=%0d y=%0d", x, y, ex, ey);
        end

        got = {lcd_de, lcd_hsync, lcd_vsync, lcd_red, lcd_green, lcd_blue};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at h=%0d v=%0d", hp, lp);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL panel_out h=%0d v=%0d: got de=%b hs=%b vs=%b rgb=%0d/%0d/%0d want de=%b hs=%b vs=%b rgb=%0d/%0d/%0d",
                         hp, lp, got.de, got.hs, got.vs, got.r, got.g, got.b,
                         e.de, e.hs, e.vs, e.r, e.g, e.b);
            end
        end
        if (got.de) de_seen++;
        if (!got.hs) hs_low++;
        if (!got.vs) vs_low++;

        if (act) begin
            red   = ex[4:0];
            green = 6'($urandom);
            blue  = 5'($urandom);
        end else begin
            red   = 5'd31;
            green = 6'd63;
            blue  = 5'd31;
        end

        e.de = act;
        e.hs = !hsy;
        e.vs = !vsy;
        e.r  = '0;
        e.g  = '0;
        e.b  = '0;
        if (act) begin
`ifdef LCD_480X272_SCAN_TEST_PATTERN_EN
            bar = '0;
            for (int k = 1; k < 8; k++)
                if (hp >= k * (HA / 8)) bar = bar + 3'd1;
            e.r = bar[2] ? 5'd31 : 5'd0;
            e.g = bar[1] ? 6'd63 : 6'd0;
            e.b = bar[0] ? 5'd31 : 5'd0;
`else
            e.r = red;
            e.g = green;
            e.b = blue;
`endif
        end
        exp_q.push_back(e);

        for (int j = 0; j < PD; j++) begin
            fs_exp = (j == 0) && (hp == 0) && (lp == 0) && (frames > 0);
            checks++;
            if (lcd_pclk !== 1'(j >= PD / 2)) begin
                errors++;
                $display("FAIL pclk phase %0d: got %b want %b", j, lcd_pclk, 1'(j >= PD / 2));
            end
            checks++;
            if (frame_start !== fs_exp) begin
                errors++;
                $display("FAIL frame_start h=%0d v=%0d j=%0d: got %b want %b",
                         hp, lp, j, frame_start, fs_exp);
            end
            if (j == 0 && frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != longint'(HT * VT * PD)) begin
                        errors++;
                        $display("FAIL frame_period: got %0d want %0d", cyc - last_fs, HT * VT * PD);
                    end
                end
                last_fs = cyc;
            end
            @(negedge clock);
        end

        hp++;
        if (hp == HT) begin
            hp = 0;
            lp++;
            if (lp == VT) begin
                lp = 0;
                frames++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({x, y} !== 18'd0 || lcd_de !== 1'b0 || lcd_hsync !== 1'b1 ||
            lcd_vsync !== 1'b1 || {lcd_red, lcd_green, lcd_blue} !== 16'd0 ||
            lcd_pclk !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: x=%0d y=%0d de=%b hs=%b vs=%b rgb=%h pclk=%b fs=%b want 0 0 0 1 1 0 0 0",
                     x, y, lcd_de, lcd_hsync, lcd_vsync,
                     {lcd_red, lcd_green, lcd_blue}, lcd_pclk, frame_start);
        end
        reset = 1'b0;
        for (int i = 1; i < PD; i++) begin
            @(negedge clock);
            checks++;
            if (x !== 9'd0) begin
                errors++;
                $display("FAIL first_tick clk %0d: got x=%0d want 0", i, x);
            end
        end
        @(negedge clock);
        checks++;
        if (x !== 9'd1) begin
            errors++;
            $display("FAIL first_tick clk %0d: got x=%0d want 1", PD, x);
        end
    endtask

    task automatic test_scan_frames();
        do_reset();
        step_pixel();
        for (int f = 0; f < 2; f++) begin
            de_seen = 0;
            hs_low  = 0;
            vs_low  = 0;
            for (int i = 0; i < HT * VT; i++) step_pixel();
            checks++;
            if (de_seen != HA * VA) begin
                errors++;
                $display("FAIL de_count frame %0d: got %0d want %0d", f, de_seen, HA * VA);
            end
            checks++;
            if (hs_low != HS * VT) begin
                errors++;
                $display("FAIL hsync_low frame %0d: got %0d want %0d", f, hs_low, HS * VT);
            end
            checks++;
            if (vs_low != VS * HT) begin
                errors++;
                $display("FAIL vsync_low frame %0d: got %0d want %0d", f, vs_low, VS * HT);
            end
        end
        checks++;
        if (frames != 2) begin
            errors++;
            $display("FAIL frame_model: got %0d want 2", frames);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        do_reset();
        n = 0;
        while (n < 2 * HT * VT && !(hp == HA / 2 && lp == VA / 2)) begin
            step_pixel();
            n++;
        end
        checks++;
        if (x !== 9'(HA / 2) || y !== 9'(VA / 2) || lcd_de !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_setup: got x=%0d y=%0d de=%b want %0d %0d 1",
                     x, y, lcd_de, HA / 2, VA / 2);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({x, y} !== 18'd0 || lcd_de !== 1'b0 || lcd_hsync !== 1'b1 ||
            lcd_vsync !== 1'b1 || {lcd_red, lcd_green, lcd_blue} !== 16'd0 ||
            lcd_pclk !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: x=%0d y=%0d de=%b hs=%b vs=%b rgb=%h pclk=%b fs=%b",
                     x, y, lcd_de, lcd_hsync, lcd_vsync,
                     {lcd_red, lcd_green, lcd_blue}, lcd_pclk, frame_start);
        end
        do_reset();
        for (int i = 0; i < HT * VT + 2 * HT; i++) step_pixel();
        checks++;
        if (last_fs < 0) begin
            errors++;
            $display("FAIL restart_frame_start: got none want one pulse");
        end
    endtask

    initial begin
        test_reset();
        test_scan_frames();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_480x272_scan.md
# lcd_480x272_scan

Scan generator and pixel output stage for the 480×272 RGB LCD on the Tang Nano 9K board. It produces the `x`/`y` coordinates that user drawing logic consumes, and samples the `red`/`green`/`blue` values that logic returns. It re-times those values, with DE, HSYNC, VSYNC and pixel clock, onto the LCD pins. It sits between the board top and the user drawing block, and is the driving end of the `x`/`y`/RGB interface.

## Interface
- `pclk_div`, default 3: system clocks per pixel; ≥2. 27 MHz / 3 = 9 MHz.
- `h_active`, default 480; `h_front`, default 2; `h_sync`, default 41; `h_back`, default 2: horizontal phase lengths in pixels, each ≥1; `h_active` ≤ 512.
- `v_active`, default 272; `v_front`, default 2; `v_sync`, default 10; `v_back`, default 2: vertical phase lengths in lines, each ≥1; `v_active` ≤ 512.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `x` out 9: current active column; 0 outside the active region.
- `y` out 9: current active row; 0 outside the active region.
- `red` in 5, `green` in 6, `blue` in 5: pixel colour for the current `x`/`y`, sampled in the same cycle.
- `frame_start` out 1: one-clock pulse when pixel (0,0) begins.
- `lcd_pclk` out 1: pixel clock to the panel.
- `lcd_de` out 1: data enable, active-high.
- `lcd_hsync` out 1, `lcd_vsync` out 1: sync outputs, active-low.
- `lcd_red` out 5, `lcd_green` out 6, `lcd_blue` out 5: registered colour to the panel.

## Operation
- Divider `div_cnt` counts 0..`pclk_div`-1 and wraps. `tick` is asserted when `div_cnt` = `pclk_div`-1. All scan state advances only on `tick`.
- `lcd_pclk` = 0 while `div_cnt` < `pclk_div`/2 (integer division), otherwise 1.
- Horizontal FSM states are ACTIVE, FRONT, SYNC and BACK, each with a phase counter.
  - On `tick`, the phase counter increments. At (phase length − 1) the counter clears and the FSM moves ACTIVE→FRONT→SYNC→BACK→ACTIVE.
- The vertical FSM has the same four states. It advances by one line on the `tick` where the horizontal FSM leaves BACK (end of line).
- Active region = horizontal ACTIVE and vertical ACTIVE. Inside it, `x` = horizontal phase counter and `y` = vertical phase counter; outside it, both are 0.
- `x` and `y` are registered state, not combinational decodes of the divider.
- Output register, loaded on `tick`:
  - `lcd_de` ← active region.
  - `lcd_hsync` ← not(horizontal SYNC).
  - `lcd_vsync` ← not(vertical SYNC).
  - `lcd_red`/`lcd_green`/`lcd_blue` ← `red`/`green`/`blue` when the active region is asserted, else 0.
- `frame_start` = 1 for exactly the one clock in which both FSMs enter ACTIVE with counters at 0.
- Width rules:
  - Phase counters are 10 bits and compare against 10-bit-extended parameters.
  - Colour passes through unmodified; there is no truncation or rounding.

## Timing
- Reset values:
  - `div_cnt` = 0.
  - Both FSMs in ACTIVE with counters at 0, so `x` = 0 and `y` = 0.
  - `lcd_de` = 0; `lcd_hsync` = 1; `lcd_vsync` = 1; all `lcd_*` colour outputs = 0; `lcd_pclk` = 0; `frame_start` = 0.
- Pixel (0,0) is presented on `x`/`y` immediately after reset deasserts. `frame_start` is not pulsed for this first frame; it first pulses at the start of frame 2.
- User logic has `pclk_div` clocks to settle RGB after an `x`/`y` change.
- Latency: panel outputs lag `x`/`y` by exactly one pixel period. DE and syncs are delayed by the same register, so everything stays aligned.
- Data changes at the clock where `div_cnt` wraps to 0. `lcd_pclk` rises `pclk_div`/2 clocks later, which gives the panel setup margin.
- Default line = 525 pixels, default frame = 286 lines, giving 450 450 clocks/frame (≈59.94 Hz at 27 MHz).
- If reset is asserted mid-frame, all state returns to reset values on the next clock and the scan restarts at (0,0). No partial sync pulse is stretched.

## Configuration
- Macro: `LCD_480X272_SCAN_TEST_PATTERN_EN`.
- Defined: `red`/`green`/`blue` are ignored and the panel shows 8 vertical bars of width `h_active`/8.
  - Bar index `b` = `x` / (`h_active`/8), computed with comparators, not a divider.
  - Colour: red = `b`[2] ? 31 : 0; green = `b`[1] ? 63 : 0; blue = `b`[0] ? 31 : 0.
- Not defined: user RGB passes through as described in Operation; there is no pattern logic.

## Structure
- Package `lcd_scan_pkg` holds:
  - `scan_phase_t` enum {ACTIVE, FRONT, SYNC, BACK}.
  - Default timing localparams.
  - Counter width constant (10).
- One sub-module, `lcd_scan_axis`, instantiated twice (horizontal and vertical).
  - Inputs: `clock`, `reset`, `advance`, and the four phase lengths.
  - Outputs: `phase`, `count`, and `wrap` (leaving BACK).
- The top of the block holds the divider, active/`x`/`y` logic, the output register, `frame_start` and the optional pattern logic.

## Test plan
- Reset, then release: `x`=0, `y`=0, `lcd_hsync`=1, `lcd_vsync`=1, `lcd_de`=0; the first `tick` arrives 3 clocks after release.
- Free-run 2 frames with RGB = {x[4:0], 0, 0}:
  - `frame_start` period = 450 450 clocks.
  - `lcd_de` high for exactly 480 × 272 pixels per frame.
  - `lcd_red` equals the `x[4:0]` value from one pixel earlier.
- Per line: `lcd_hsync` low for 41 consecutive pixels (123 clocks), beginning 2 pixels after `lcd_de` falls. Per frame: `lcd_vsync` low for 10 lines = 15 750 clocks.
- In blanking, drive RGB = max (31/63/31): `lcd_*` colour outputs = 0 and `x` = `y` = 0.
- Assert reset at x=200, y=100: the next clock shows all reset values; after release, the scan resumes at (0,0) with full timing.
- With `LCD_480X272_SCAN_TEST_PATTERN_EN` defined: at x=0 output is 0/0/0; at x=60 it is 0/0/31; at x=420 it is 31/63/31. User RGB has no effect.
